rcc_rdy_irq_ctrl: RTL and testbench

Consumes the hclk-domain synchronized oscillator/PLL ready and clock-security-system fail signals produced by the RCC signal synchronizer. Detects rising edges and latches them into sticky interrupt flags (CIFR view), gated by per-source enables (CIER view), cleared by write-1-to-clear pulses (CICR view). Drives the RCC global interrupt and the HSE CSS NMI request. Sits between the synchronizer and the RCC register file / interrupt controller.

---
 rtl/rcc_rdy_irq_ctrl.sv | 76 +++++++
 tb/tb_rcc_rdy_irq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rcc_rdy_irq_ctrl.sv
// RCC ready/CSS interrupt controller: edge-detects synchronized ready and
// CSS-fail levels into sticky W1C flags that drive the RCC IRQ and HSE CSS NMI.
module rcc_rdy_irq_ctrl (
    input  logic        rcc_rcc_hclk,
    input  logic        rcc_rcc_sync_rst_n,
    input  logic        sync_lsi_rdy,
    input  logic        sync_lse_rdy,
    input  logic        sync_hsi_rdy,
    input  logic        sync_hse_rdy,
    input  logic        sync_csi_rdy,
    input  logic        sync_hsi48_rdy,
    input  logic        sync_pll1_rdy,
    input  logic        sync_pll2_rdy,
    input  logic        sync_pll3_rdy,
    input  logic        sync_lsecss_fail,
    input  logic        sync_hsecss_fail,
    input  logic [9:0]  cier,
    input  logic [10:0] cicr_clr,
    output logic [10:0] cifr,
    output logic [10:0] rdy_edge,
    output logic        rcc_it,
    output logic        rcc_hsecss_nmi
);

    logic [10:0] sync_vec;
    logic [10:0] event_w;
    logic [10:0] en_mask;
    logic [10:0] set_w;

    logic [10:0] prev_q, prev_d;
    logic [10:0] cifr_q, cifr_d;
    logic [10:0] edge_q, edge_d;

    assign sync_vec = {
        sync_hsecss_fail,
        sync_lsecss_fail,
        sync_pll3_rdy,
        sync_pll2_rdy,
        sync_pll1_rdy,
        sync_hsi48_rdy,
        sync_csi_rdy,
        sync_hse_rdy,
        sync_hsi_rdy,
        sync_lse_rdy,
        sync_lsi_rdy
    };

    // HSECSS is non-maskable, so its enable is tied high
    assign event_w = sync_vec & ~prev_q;
    assign en_mask = {1'b1, cier};
    assign set_w   = event_w & en_mask;

    always_comb begin
        prev_d = sync_vec;
        edge_d = event_w;
        cifr_d = set_w | (cifr_q & ~cicr_clr);
    end

    always_ff @(posedge rcc_rcc_hclk or negedge rcc_rcc_sync_rst_n) begin
        if (!rcc_rcc_sync_rst_n) begin
            prev_q <= '0;
            cifr_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= prev_d;
            cifr_q <= cifr_d;
            edge_q <= edge_d;
        end
    end

    assign cifr           = cifr_q;
    assign rdy_edge       = edge_q;
    assign rcc_it         = |cifr_q[9:0];
    assign rcc_hsecss_nmi = cifr_q[10];

endmodule

// File: tb/tb_rcc_rdy_irq_ctrl.sv
// Directed self-checking bench for rcc_rdy_irq_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_rcc_rdy_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [10:0] sync_v;
    logic [9:0]  cier;
    logic [10:0] cicr_clr;
    logic [10:0] cifr;
    logic [10:0] rdy_edge;
    logic        rcc_it;
    logic        rcc_hsecss_nmi;

    int n_cmp;
    int n_err;

    rcc_rdy_irq_ctrl dut (
        .rcc_rcc_hclk       (clk),
        .rcc_rcc_sync_rst_n (rst_n),
        .sync_lsi_rdy       (sync_v[0]),
        .sync_lse_rdy       (sync_v[1]),
        .sync_hsi_rdy       (sync_v[2]),
        .sync_hse_rdy       (sync_v[3]),
        .sync_csi_rdy       (sync_v[4]),
        .sync_hsi48_rdy     (sync_v[5]),
        .sync_pll1_rdy      (sync_v[6]),
        .sync_pll2_rdy      (sync_v[7]),
        .sync_pll3_rdy      (sync_v[8]),
        .sync_lsecss_fail   (sync_v[9]),
        .sync_hsecss_fail   (sync_v[10]),
        .cier               (cier),
        .cicr_clr           (cicr_clr),
        .cifr               (cifr),
        .rdy_edge           (rdy_edge),
        .rcc_it             (rcc_it),
        .rcc_hsecss_nmi     (rcc_hsecss_nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        sync_v   = 11'h004;
        cier     = 10'h004;
        cicr_clr = '0;

        // reset state, HSI already ready during reset
        #12;
        chk("rst_cifr", 32'(cifr), 32'h0);
        chk("rst_edge", 32'(rdy_edge), 32'h0);
        chk("rst_it", 32'(rcc_it), 32'h0);
        chk("rst_nmi", 32'(rcc_hsecss_nmi), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("hsi_cifr", 32'(cifr), 32'h004);
        chk("hsi_it", 32'(rcc_it), 32'h1);
        chk("hsi_edge", 32'(rdy_edge), 32'h004);
        tick();
        chk("hsi_edge1w", 32'(rdy_edge), 32'h0);
        chk("hsi_hold", 32'(cifr), 32'h004);
        cicr_clr = 11'h004;
        tick();
        cicr_clr = '0;
        chk("hsi_clr", 32'(cifr), 32'h0);
        chk("hsi_clr_it", 32'(rcc_it), 32'h0);

        // PLL1 edge while masked, enable afterwards
        cier = '0;
        sync_v[6] = 1'b1;
        tick();
        chk("pll1_edge", 32'(rdy_edge), 32'h040);
        chk("pll1_mask", 32'(cifr), 32'h0);
        cier = 10'h040;
        tick();
        chk("pll1_late", 32'(cifr), 32'h0);
        chk("pll1_it", 32'(rcc_it), 32'h0);
        chk("pll1_edge0", 32'(rdy_edge), 32'h0);
        tick();
        chk("pll1_late2", 32'(cifr), 32'h0);

        // HSE: set, clear-vs-set collision, lone clear
        cier = 10'h048;
        sync_v[3] = 1'b1;
        tick();
        chk("hse_set", 32'(cifr), 32'h008);
        sync_v[3] = 1'b0;
        tick();
        chk("hse_fall", 32'(rdy_edge), 32'h0);
        sync_v[3] = 1'b1;
        cicr_clr  = 11'h008;
        tick();
        cicr_clr = '0;
        chk("hse_setwin", 32'(cifr), 32'h008);
        chk("hse_edge2", 32'(rdy_edge), 32'h008);
        tick();
        cicr_clr = 11'h008;
        tick();
        cicr_clr = '0;
        chk("hse_clr", 32'(cifr), 32'h0);
        chk("hse_clr_it", 32'(rcc_it), 32'h0);

        // HSE CSS: non-maskable, no re-set while held high
        cier = '0;
        sync_v[10] = 1'b1;
        tick();
        chk("css_cifr", 32'(cifr), 32'h400);
        chk("css_nmi", 32'(rcc_hsecss_nmi), 32'h1);
        chk("css_it", 32'(rcc_it), 32'h0);
        cicr_clr = 11'h400;
        tick();
        cicr_clr = '0;
        chk("css_clr", 32'(cifr), 32'h0);
        chk("css_clr_nmi", 32'(rcc_hsecss_nmi), 32'h0);
        tick();
        chk("css_noreset", 32'(cifr), 32'h0);

        // all sources simultaneously
        sync_v = '0;
        tick();
        chk("all_low", 32'(cifr), 32'h0);
        cier   = 10'h3FF;
        sync_v = 11'h7FF;
        tick();
        chk("all_cifr", 32'(cifr), 32'h7FF);
        chk("all_edge", 32'(rdy_edge), 32'h7FF);
        chk("all_it", 32'(rcc_it), 32'h1);
        cicr_clr = 11'h7FF;
        tick();
        cicr_clr = '0;
        chk("all_clr", 32'(cifr), 32'h0);

        // async reset mid-cycle with cifr = 155
        sync_v = '0;
        tick();
        sync_v = 11'h155;
        tick();
        chk("pre_rst", 32'(cifr), 32'h155);
        chk("pre_rst_edge", 32'(rdy_edge), 32'h155);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cifr", 32'(cifr), 32'h0);
        chk("arst_edge", 32'(rdy_edge), 32'h0);
        chk("arst_it", 32'(rcc_it), 32'h0);
        chk("arst_nmi", 32'(rcc_hsecss_nmi), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("refire_cifr", 32'(cifr), 32'h155);
        chk("refire_edge", 32'(rdy_edge), 32'h155);
        tick();
        chk("refire_once", 32'(rdy_edge), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
